// File: rtl/router_output_arbiter.sv
// router_output_arbiter: round-robin arbiter of four flit sources into a small output FIFO
module router_output_arbiter #(
  parameter int WIDTH = 11,
  parameter int IDW   = 3,
  parameter int DEPTH = 2,
  parameter int CNTW  = 16
) (
  input  logic              clk,
  input  logic              _RESET,
  input  logic [3:0]        in_valid,
  output logic [3:0]        in_ready,
  input  logic [4*WIDTH-1:0] in_data,
  input  logic [4*IDW-1:0]  in_id,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [IDW-1:0]    out_id,
  output logic [1:0]        out_src,
  output logic [CNTW-1:0]   pkt_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = WIDTH + IDW + 2;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    rr_ptr, win, idx;
  logic          any, push, pop;
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_ptr + 2'(k);
      if (in_valid[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end
  assign in_ready  = (_RESET && any && count < (AW+1)'(DEPTH)) ? 4'b0001 << win : 4'b0000;
  assign push      = |(in_valid & in_ready);
  assign out_valid = count != '0;
  assign pop       = out_valid && out_ready;
  assign head      = mem[rd_ptr];
  assign out_data  = out_valid ? head[EW-1 -: WIDTH] : '0;
  assign out_id    = out_valid ? head[IDW+1 -: IDW] : '0;
  assign out_src   = out_valid ? head[1:0] : '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_data[win*WIDTH +: WIDTH], in_id[win*IDW +: IDW], win};
  always_ff @(posedge clk or negedge _RESET)
    if (!_RESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rr_ptr    <= '0;
      pkt_count <= '0;
    end else begin
      wr_ptr    <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr    <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count     <= count + (AW+1)'(push) - (AW+1)'(pop);
      rr_ptr    <= push ? win + 2'd1 : rr_ptr;
      pkt_count <= (push && !(&pkt_count)) ? pkt_count + CNTW'(1) : pkt_count;
    end
endmodule

// File: tb/tb_router_output_arbiter.sv
// tb_router_output_arbiter: table-driven check of arbitration, FIFO order, backpressure, reset and saturation
module tb_router_output_arbiter;
  localparam int WIDTH = 11;
  localparam int IDW   = 3;
  logic              clk = 1'b0;
  logic              _RESET = 1'b0;
  logic [3:0]        in_valid = '0;
  logic [3:0]        in_ready, s_in_ready;
  logic [4*WIDTH-1:0] in_data;
  logic [4*IDW-1:0]  in_id;
  logic              out_valid, s_out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  out_data, s_out_data;
  logic [IDW-1:0]    out_id, s_out_id;
  logic [1:0]        out_src, s_out_src;
  logic [15:0]       pkt_count;
  logic [3:0]        s_pkt_count;
  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] dat [4];
  logic [IDW-1:0]   idv [4];
  typedef struct {
    bit         rst;
    logic [3:0] v;
    bit         ordy;
    logic [3:0] e_ready;
    bit         e_ov;
    logic [1:0] e_src;
    int         e_pkt;
  } vec_t;
  vec_t tbl [$];
  always #10 clk = ~clk;
  router_output_arbiter dut (
    .clk(clk), ._RESET(_RESET), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_id(in_id), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .out_src(out_src), .pkt_count(pkt_count)
  );
  router_output_arbiter #(.CNTW(4)) sat (
    .clk(clk), ._RESET(_RESET), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_id(in_id), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_id(s_out_id), .out_src(s_out_src), .pkt_count(s_pkt_count)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input bit rst, input logic [3:0] v, input bit ordy,
                              input logic [3:0] e_ready, input bit e_ov,
                              input logic [1:0] e_src, input int e_pkt);
    vec_t t;
    t.rst = rst; t.v = v; t.ordy = ordy; t.e_ready = e_ready;
    t.e_ov = e_ov; t.e_src = e_src; t.e_pkt = e_pkt;
    return t;
  endfunction
  task automatic pulse_reset;
    _RESET = 1'b0;
    #1;
    _RESET = 1'b1;
  endtask
  initial begin
    dat[0] = 11'h0A1; dat[1] = 11'h1B2; dat[2] = 11'h5A3; dat[3] = 11'h7C4;
    idv[0] = 3'b101;  idv[1] = 3'b110;  idv[2] = 3'b010;  idv[3] = 3'b011;
    for (int i = 0; i < 4; i++) begin
      in_data[i*WIDTH +: WIDTH] = dat[i];
      in_id[i*IDW +: IDW]       = idv[i];
    end
    tbl.push_back(mk(1, 4'b0100, 1, 4'b0100, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0101, 1, 4'b0001, 1, 2, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 1, 0, 2));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 0, 2));
    tbl.push_back(mk(1, 4'b1111, 1, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0010, 1, 0, 1));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0100, 1, 1, 2));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b1000, 1, 2, 3));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 1, 3, 4));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0010, 1, 0, 5));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0100, 1, 1, 6));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b1000, 1, 2, 7));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 1, 3, 8));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 0, 8));
    tbl.push_back(mk(0, 4'b1010, 0, 4'b0010, 0, 0, 8));
    tbl.push_back(mk(0, 4'b1010, 0, 4'b1000, 1, 1, 9));
    tbl.push_back(mk(0, 4'b1010, 0, 4'b0000, 1, 1, 10));
    tbl.push_back(mk(0, 4'b1010, 0, 4'b0000, 1, 1, 10));
    tbl.push_back(mk(0, 4'b1010, 1, 4'b0000, 1, 1, 10));
    tbl.push_back(mk(0, 4'b1010, 0, 4'b0010, 1, 3, 10));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 1, 3, 11));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 1, 1, 11));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 0, 11));
    tbl.push_back(mk(0, 4'b0001, 1, 4'b0001, 0, 0, 11));
    tbl.push_back(mk(0, 4'b1000, 1, 4'b1000, 1, 0, 12));
    tbl.push_back(mk(0, 4'b0010, 1, 4'b0010, 1, 3, 13));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 1, 1, 14));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 14));
    #5;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_pkt_count", int'(pkt_count), 0);
    chk("reset_out_data", int'(out_data), 0);
    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge clk);
      if (tbl[r].rst) pulse_reset();
      in_valid  = tbl[r].v;
      out_ready = tbl[r].ordy;
      #1;
      chk($sformatf("row%0d_in_ready", r), int'(in_ready), int'(tbl[r].e_ready));
      chk($sformatf("row%0d_out_valid", r), int'(out_valid), int'(tbl[r].e_ov));
      chk($sformatf("row%0d_out_src", r), int'(out_src), int'(tbl[r].e_src));
      chk($sformatf("row%0d_out_data", r), int'(out_data), tbl[r].e_ov ? int'(dat[tbl[r].e_src]) : 0);
      chk($sformatf("row%0d_out_id", r), int'(out_id), tbl[r].e_ov ? int'(idv[tbl[r].e_src]) : 0);
      chk($sformatf("row%0d_pkt_count", r), int'(pkt_count), tbl[r].e_pkt);
      chk($sformatf("row%0d_sat_pkt", r), int'(s_pkt_count), tbl[r].e_pkt > 15 ? 15 : tbl[r].e_pkt);
    end
    @(negedge clk);
    in_valid = 4'b0011;
    out_ready = 1'b0;
    #1;
    chk("rst_fill0_ready", int'(in_ready), 4'b0001);
    @(negedge clk);
    #1;
    chk("rst_fill1_ready", int'(in_ready), 4'b0010);
    @(negedge clk);
    #1;
    chk("rst_full_ready", int'(in_ready), 0);
    chk("rst_full_head", int'(out_src), 0);
    #2;
    _RESET = 1'b0;
    #1;
    chk("async_out_valid", int'(out_valid), 0);
    chk("async_in_ready", int'(in_ready), 0);
    chk("async_pkt_count", int'(pkt_count), 0);
    chk("async_out_data", int'(out_data), 0);
    chk("async_out_id", int'(out_id), 0);
    chk("async_out_src", int'(out_src), 0);
    chk("async_sat_pkt", int'(s_pkt_count), 0);
    in_valid = 4'b1100;
    _RESET = 1'b1;
    #1;
    chk("post_rst_ready", int'(in_ready), 4'b0100);
    @(negedge clk);
    #1;
    chk("post_rst_head", int'(out_src), 2);
    chk("post_rst_valid", int'(out_valid), 1);
    chk("post_rst_pkt", int'(pkt_count), 1);
    @(negedge clk);
    pulse_reset();
    in_valid = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk($sformatf("sat%0d_ready", k), int'(in_ready), int'(4'b0001 << (k % 4)));
      chk($sformatf("sat%0d_cnt4", k), int'(s_pkt_count), k > 15 ? 15 : k);
      @(negedge clk);
    end
    in_valid = 4'b0000;
    #1;
    chk("sat_main_pkt", int'(pkt_count), 20);
    chk("sat_cnt4_pkt", int'(s_pkt_count), 15);
    @(negedge clk);
    #1;
    chk("drain_valid", int'(out_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/router_output_arbiter.md
Name: router_output_arbiter

Overview:
Clocked output-port stage of a router node. It sits directly downstream of the path-computation/split stages of the four input ports. Each split stage delivers one 11-bit flit (data[10:4] payload, data[3:0] destination address) plus its 3-bit source ID toward this output port. The block arbitrates the four requesters round-robin, buffers winners in a small FIFO, and presents one flit/ID pair per handshake to the outgoing link.

Parameters:
WIDTH, 11, flit width in bits
IDW, 3, source-ID width in bits
DEPTH, 2, output FIFO entries (power of two, >=2)
CNTW, 16, width of the accepted-flit counter

Ports:
clk  input  1  rising-edge clock
_RESET  input  1  asynchronous active-low reset
in_valid  input  4  per-requester flit valid
in_ready  output  4  per-requester accept; one-hot or zero
in_data  input  4*WIDTH  flit of requester i at [i*WIDTH +: WIDTH]
in_id  input  4*IDW  source ID of requester i at [i*IDW +: IDW]
out_valid  output  1  FIFO head valid
out_ready  input  1  downstream accept
out_data  output  WIDTH  head flit
out_id  output  IDW  head source ID
out_src  output  2  requester index the head flit came from
pkt_count  output  CNTW  saturating count of accepted flits

Behaviour:
- Reset (_RESET low, asynchronous): FIFO emptied, rr_ptr=0, pkt_count=0.
  - Outputs during reset: out_valid=0, in_ready=0, out_data/out_id/out_src=0.
  - Release takes effect at the next clk edge.
- Transfers complete on a rising clk edge. An input transfer is in_valid[i]&in_ready[i]. An output transfer is out_valid&out_ready.
- Arbitration (combinational from registered state):
  - Search order rr_ptr, rr_ptr+1, … mod 4. The first i with in_valid[i]=1 wins.
  - in_ready[i]=1 only for the winner, and only when FIFO count<DEPTH.
  - in_ready never depends on out_ready, so there is no combinational ready path through the block.
- Pointer update: on an input transfer from requester i, rr_ptr <= (i+1) mod 4. With no transfer, rr_ptr holds.
  - A requester that just won therefore has lowest priority next cycle.
  - Every continuously-requesting source is served within 4 accepts.
- FIFO:
  - Push writes {in_data[i], in_id[i], i}.
  - out_valid = (count!=0). out_data/out_id/out_src show the head entry and are stable while out_valid=1 and out_ready=0.
  - Latency: a flit accepted at edge N appears with out_valid=1 immediately after edge N (one cycle, no bypass).
  - Simultaneous push and pop at count 1..DEPTH-1: count unchanged, order preserved.
  - When count==DEPTH, in_ready=0. A pop in that cycle frees space, and acceptance resumes the following cycle.
  - Pointers wrap mod DEPTH.
  - out_ready with an empty FIFO has no effect.
- Input data and IDs pass through unmodified. No address decoding is done here.
- pkt_count increments by 1 on each input transfer and saturates at 2^CNTW-1.
- Input sources must hold in_valid, in_data and in_id stable until accepted. The block does not check this.
- Reset asserted mid-transfer: all buffered flits are discarded and there is no partial output. Upstream must re-send after reset.

Test Plan:
1. Single source: in_valid=4'b0100, in_data[2]=11'h5A3, in_id[2]=3'b010, out_ready=1. Required response:
   - in_ready=4'b0100 at that edge.
   - Next cycle: out_valid=1, out_data=11'h5A3, out_id=3'b010, out_src=2, rr_ptr=3, pkt_count=1.
2. All four requesting continuously, out_ready=1, from reset: grant order 0,1,2,3,0,… is required.
   - One flit leaves per cycle.
   - pkt_count=8 after 8 accepts.
3. Backpressure: out_ready=0, sources 1 and 3 valid. Required response:
   - Accepts are 1 then 3.
   - in_ready=0 once count=2.
   - Head holds 11'h… of source 1 stable.
   - Raising out_ready pops source 1's flit, and a new accept occurs on the following edge.
4. Push and pop in the same cycle at count=1: count stays 1 and output order matches accept order.
5. Assert _RESET low asynchronously between edges with 2 entries queued. Required response:
   - out_valid and in_ready drop immediately, and pkt_count=0.
   - After release, the first grant goes to the lowest valid index ≥0.
6. Saturation with CNTW=4: 20 accepts leave pkt_count=15.
